// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   - loader FSM state encoding
//   - stream framing constants (header length, bytes per word)
//   - checksum width used when IMEM_LOADER_CHECKSUM_EN is defined
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    RUN    = 3'd5
  } state_t;

  localparam int BYTE_W     = 8;
  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;
  localparam int COUNT_W    = HDR_BYTES * BYTE_W;
  localparam int CSUM_W     = 32;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Byte-stream valid/ready handshake between the serial receiver and the loader.
//   rx_data  : stream byte
//   rx_valid : rx_data valid (driven by the source)
//   rx_ready : loader accepts the byte this cycle
// Modports: master = byte source, slave = loader.
// -----------------------------------------------------------------------------
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/imem_word_assembler.sv
// -----------------------------------------------------------------------------
// imem_word_assembler
// Big-endian byte-to-word assembler: shifts accepted bytes in MSB first and
// flags the 4th byte of each word.
//   clk, reset  : clock, asynchronous active-high reset
//   clr         : restart at byte 0 (start of a new load)
//   byte_en     : a byte is accepted this cycle
//   byte_in     : accepted byte
//   word_valid  : byte_en on the 4th byte of a word (combinational)
//   word        : completed word, valid with word_valid
// -----------------------------------------------------------------------------
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int CW = $clog2(WORD_BYTES);
  localparam int SW = WORD_W - BYTE_W;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_en) begin
      // Counter wraps modulo WORD_BYTES, so it is back at 0 for the next word.
      cnt_d   = cnt_q + CW'(1);
      shift_d = {shift_q[SW-BYTE_W-1:0], byte_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign word_valid = byte_en && (cnt_q == CW'(WORD_BYTES - 1));
  assign word       = {shift_q, byte_in};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot/reload controller for the instruction memory. Receives a byte stream
// (2-byte big-endian word count N, then N big-endian 32-bit words), writes the
// words into the instruction memory and holds the CPU while loading. In RUN the
// memory address port is handed back to the PC fetch path.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load_req    : single-cycle reload request, honoured only in RUN
//   rx          : byte-stream handshake (imem_loader_if.slave)
//   cpu_addr    : PC byte address, used as word index in RUN
//   mem_addr    : word index to instruction memory
//   mem_we      : instruction memory write enable
//   mem_wdata   : word to write
//   cpu_hold    : CPU hold, high in every state except RUN
//   load_done   : one-cycle pulse on entry to RUN after a load
//   load_err    : sticky error flag (oversize header / checksum mismatch)
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a 4-byte XOR
// checksum trailer after the data words (CHK state).
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_SIZE = 128,
  parameter int AW       = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  imem_loader_if.slave      rx,
  input  logic [31:0]       cpu_addr,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  // One bit wider than AW so a full MEM_SIZE load can count past the last index.
  logic [AW:0]          widx_q, widx_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 load_done_q, load_done_d;
  logic                 load_err_q, load_err_d;

  logic                 accept;
  logic                 asm_en;
  logic                 asm_clr;
  logic                 word_valid;
  logic [WORD_W-1:0]    word;
  logic [COUNT_W-1:0]   hdr_n;
  logic                 last_word;
  logic                 unused_cpu_addr;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0]    csum_q, csum_d;
`endif

  assign accept    = rx.rx_valid && rx_ready_q;
  assign asm_en    = accept && ((state_q == DATA) || (state_q == CHK));
  assign asm_clr   = accept && (state_q == HDR_LO);
  assign hdr_n     = {count_q[COUNT_W-1:BYTE_W], rx.rx_data};
  // widx_q still holds this word's index: the previous write's increment has
  // long since landed because a word takes at least 4 cycles to arrive.
  assign last_word = (COUNT_W'(widx_q) == count_q - COUNT_W'(1));

  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (asm_clr),
    .byte_en    (asm_en),
    .byte_in    (rx.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    widx_d      = widx_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;

    // Word index advances at the end of each write cycle.
    if (mem_we_q) widx_d = widx_q + (AW+1)'(1);

    case (state_q)
      HDR_HI: begin
        if (accept) begin
          count_d[COUNT_W-1:BYTE_W] = rx.rx_data;
          state_d                   = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = hdr_n;
          widx_d  = '0;
          if (hdr_n == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else if (hdr_n > COUNT_W'(MEM_SIZE)) begin
            load_err_d = 1'b1;
            state_d    = HDR_HI;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = word;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (word_valid) begin
          if (word == csum_q) begin
            state_d = DONE;
          end else begin
            load_err_d = 1'b1;
            state_d    = HDR_HI;
          end
        end
      end
`endif
      DONE: begin
        state_d     = RUN;
        load_done_d = 1'b1;
      end
      RUN: begin
        if (load_req) begin
          state_d = HDR_HI;
          widx_d  = '0;
        end
      end
      default: state_d = HDR_HI;
    endcase

    // A load reaching DONE clears any error left from an earlier attempt.
    if (state_d == DONE) load_err_d = 1'b0;

    // Handshake-facing outputs are registered from the next state.
    rx_ready_d = (state_d != DONE) && (state_d != RUN);
    cpu_hold_d = (state_d != RUN);
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (asm_clr)                          csum_d = '0;
    else if (word_valid && state_q == DATA) csum_d = csum_q ^ word;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HDR_HI;
      count_q     <= '0;
      widx_q      <= '0;
      rx_ready_q  <= 1'b1;
      cpu_hold_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      widx_q      <= widx_d;
      rx_ready_q  <= rx_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // In RUN the PC owns the address port; upper address bits are ignored.
  assign mem_addr    = (state_q == RUN) ? cpu_addr[AW+1:2] : widx_q[AW-1:0];
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_hold    = cpu_hold_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign rx.rx_ready = rx_ready_q;

  assign unused_cpu_addr = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed self-checking bench for imem_loader. Inputs change 1 ns after the
// rising edge; outputs are sampled in the same window.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_req = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  imem_loader_if rx_if ();

  imem_loader #(.MEM_SIZE(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_req  (load_req),
    .rx        (rx_if),
    .cpu_addr  (cpu_addr),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: a write lands at the end of the cycle in which mem_we is high.
  logic [31:0] tb_mem [0:127];
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] = mem_wdata;
      wr_cnt           = wr_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    while (!rx_if.rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (!rx_if.rx_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: rx_ready=%b required 1", rx_if.rx_ready);
    end
    tick();
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 3; i >= 0; i--) send_byte(tmp[i*8 +: 8]);
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    for (int i = 0; i < 128; i++) tb_mem[i] = 32'h0;
    tick();
    tick();
    n_tests++;
    if ({rx_if.rx_ready, cpu_hold, mem_we, load_done, load_err} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy/hold/we/done/err=%b required 11000",
               {rx_if.rx_ready, cpu_hold, mem_we, load_done, load_err});
    end
    n_tests++;
    if (mem_wdata !== 32'h0 || mem_addr !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_data: wdata=%h addr=%0d required 0 0", mem_wdata, mem_addr);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (rx_if.rx_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: rdy=%b hold=%b required 1 1", rx_if.rx_ready, cpu_hold);
    end
  endtask

  task automatic test_basic_load();
    int w0;
    w0 = wr_cnt;
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h24080005);
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr !== 7'd0 || mem_wdata !== 32'h24080005) begin
      n_fail++;
      $display("FAIL basic_w0: we=%b addr=%0d data=%h required 1 0 24080005",
               mem_we, mem_addr, mem_wdata);
    end
    send_byte(8'h00);
    n_tests++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_we_width: we=%b required 0", mem_we);
    end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr !== 7'd1 || mem_wdata !== 32'h00000008) begin
      n_fail++;
      $display("FAIL basic_w1: we=%b addr=%0d data=%h required 1 1 00000008",
               mem_we, mem_addr, mem_wdata);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h2408000D);
`endif
    n_tests++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b1 || rx_if.rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_state: done=%b hold=%b rdy=%b required 0 1 0",
               load_done, cpu_hold, rx_if.rx_ready);
    end
    tick();
    n_tests++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_run_entry: done=%b hold=%b we=%b required 1 0 0",
               load_done, cpu_hold, mem_we);
    end
    tick();
    n_tests++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b hold=%b required 0 0", load_done, cpu_hold);
    end
    cpu_addr = 32'h0000_0004;
    #1;
    n_tests++;
    if (mem_addr !== 7'd1) begin
      n_fail++;
      $display("FAIL run_addr_4: mem_addr=%0d required 1", mem_addr);
    end
    cpu_addr = 32'hFFFF_FF0C;
    #1;
    n_tests++;
    if (mem_addr !== 7'd67) begin
      n_fail++;
      $display("FAIL run_addr_upper: mem_addr=%0d required 67", mem_addr);
    end
    n_tests++;
    if (wr_cnt - w0 !== 2 || tb_mem[0] !== 32'h24080005 || tb_mem[1] !== 32'h00000008) begin
      n_fail++;
      $display("FAIL basic_mem: writes=%0d mem0=%h mem1=%h required 2 24080005 00000008",
               wr_cnt - w0, tb_mem[0], tb_mem[1]);
    end
    cpu_addr = 32'h0;
  endtask

  task automatic test_oversize();
    int w0;
    w0 = wr_cnt;
    pulse_load_req();
    n_tests++;
    if (cpu_hold !== 1'b1 || rx_if.rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_enter: hold=%b rdy=%b required 1 1", cpu_hold, rx_if.rx_ready);
    end
    send_byte(8'h00); send_byte(8'h81);
    n_tests++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || rx_if.rx_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize: err=%b hold=%b rdy=%b we=%b required 1 1 1 0",
               load_err, cpu_hold, rx_if.rx_ready, mem_we);
    end
    tick();
    tick();
    n_tests++;
    if (wr_cnt !== w0 || load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_sticky: writes=%0d err=%b hold=%b required 0 1 1",
               wr_cnt - w0, load_err, cpu_hold);
    end
  endtask

  // Starts in HDR_HI left by the oversize header; every byte is followed by an idle cycle.
  task automatic test_throttled_load();
    logic [7:0] bytes [0:13];
    int w0;
    bytes = '{8'h00, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2,
              8'hB3, 8'hB4, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    w0 = wr_cnt;
    for (int i = 0; i < 14; i++) begin
      send_byte(bytes[i]);
      if (i != 13) tick();
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    tick();
    send_word(32'hD1D2D3D4);
`endif
    n_tests++;
    if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL throttle_err_clear: err=%b hold=%b required 0 1", load_err, cpu_hold);
    end
    tick();
    n_tests++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_done: done=%b hold=%b required 1 0", load_done, cpu_hold);
    end
    tick();
    n_tests++;
    if (wr_cnt - w0 !== 3 || tb_mem[0] !== 32'hA1A2A3A4 || tb_mem[1] !== 32'hB1B2B3B4 ||
        tb_mem[2] !== 32'hC1C2C3C4) begin
      n_fail++;
      $display("FAIL throttle_mem: writes=%0d m0=%h m1=%h m2=%h required 3 A1A2A3A4 B1B2B3B4 C1C2C3C4",
               wr_cnt - w0, tb_mem[0], tb_mem[1], tb_mem[2]);
    end
  endtask

  task automatic test_reset_midload();
    pulse_load_req();
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h11223344);
    send_byte(8'h55); send_byte(8'h66);
    reset = 1'b1;
    #1;
    n_tests++;
    if (mem_we !== 1'b0 || mem_addr !== 7'd0 || mem_wdata !== 32'h0 ||
        cpu_hold !== 1'b1 || rx_if.rx_ready !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: we=%b addr=%0d data=%h hold=%b rdy=%b done=%b err=%b required 0 0 0 1 1 0 0",
               mem_we, mem_addr, mem_wdata, cpu_hold, rx_if.rx_ready, load_done, load_err);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'hDEADBEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'hDEADBEEF);
`endif
    tick();
    n_tests++;
    if (load_done !== 1'b1 || tb_mem[0] !== 32'hDEADBEEF || tb_mem[1] !== 32'hB1B2B3B4) begin
      n_fail++;
      $display("FAIL fresh_load: done=%b m0=%h m1=%h required 1 DEADBEEF B1B2B3B4",
               load_done, tb_mem[0], tb_mem[1]);
    end
    tick();
  endtask

  task automatic test_reload_zero();
    int hold_cycles;
    int w0;
    int nb;
    int exp_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
    nb = 6;
`else
    nb = 2;
`endif
    exp_hold = nb + 1;
    w0 = wr_cnt;
    n_tests++;
    if (cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pre_run: hold=%b required 0", cpu_hold);
    end
    pulse_load_req();
    hold_cycles = 0;
    for (int i = 0; i < nb; i++) begin
      if (cpu_hold) hold_cycles++;
      rx_if.rx_valid = 1'b1;
      rx_if.rx_data  = 8'h00;
      tick();
    end
    rx_if.rx_valid = 1'b0;
    while (cpu_hold && hold_cycles < 20) begin
      hold_cycles++;
      tick();
    end
    n_tests++;
    if (load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done=%b required 1", load_done);
    end
    n_tests++;
    if (hold_cycles !== exp_hold) begin
      n_fail++;
      $display("FAIL zero_hold_len: hold cycles=%0d required %0d", hold_cycles, exp_hold);
    end
    n_tests++;
    if (wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL zero_no_write: writes=%0d required 0", wr_cnt - w0);
    end
    tick();
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_load_req();
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    tick();
    n_tests++;
    if (load_done !== 1'b1 || load_err !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_good: done=%b err=%b hold=%b required 1 0 0", load_done, load_err, cpu_hold);
    end
    tick();
    pulse_load_req();
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333334);
    tick();
    n_tests++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0 || rx_if.rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL csum_bad: err=%b hold=%b done=%b rdy=%b required 1 1 0 1",
               load_err, cpu_hold, load_done, rx_if.rx_ready);
    end
  endtask
`endif

  initial begin
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    #1;
    test_reset();
    test_basic_load();
    test_oversize();
    test_throttled_load();
    test_reset_midload();
    test_reload_zero();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot/reload controller for the instruction memory. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words into the instruction memory's write port and holds the CPU while loading. When the load completes, it hands the memory address port back to the PC fetch path. It sits between the serial receiver, the PC, and the instruction memory.

## Interface
- MEM_SIZE, 128, instruction memory depth in 32-bit words
- AW, $clog2(MEM_SIZE), word-index width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- load_req  in  1  single-cycle request to reload; honoured only in RUN
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte this cycle
- cpu_addr  in  32  byte address from PC
- mem_addr  out  AW  word index to instruction memory
- mem_we  out  1  instruction memory write enable
- mem_wdata  out  32  word to write
- cpu_hold  out  1  CPU stall/reset-hold while loading
- load_done  out  1  one-cycle pulse on entry to RUN after a successful load
- load_err  out  1  sticky error flag

## Operation
- Stream format: 2-byte word count N (MSB first), then N words, 4 bytes each with MSB first.
- States: HDR_HI, HDR_LO, DATA, CHK (macro only), DONE, RUN.
- A byte is accepted only when rx_valid and rx_ready are both high. rx_ready=1 in HDR_HI, HDR_LO, DATA and CHK; 0 in DONE and RUN.
- HDR_HI: latch count[15:8] → HDR_LO.
- HDR_LO: latch count[7:0].
  - N=0 → DONE.
  - N>MEM_SIZE → set load_err, → HDR_HI.
  - Otherwise → DATA with word index 0 and byte counter 0.
- DATA: shift each byte in.
  - On the 4th byte, register the word and issue the write (see Timing).
  - Word index increments after each write.
  - After word N−1: → CHK if the macro is defined, else → DONE.
- DONE: one cycle → RUN.
- RUN: on load_req → HDR_HI; cpu_hold rises the next cycle.
- Address mux:
  - RUN: mem_addr = cpu_addr[AW+1:2]. Upper bits are ignored; no range check.
  - All other states: mem_addr = loader word index.
- mem_we is driven only by the loader and is never high in RUN.
- cpu_hold=1 in every state except RUN.
- Memory contents beyond word N−1 are left untouched.

## Timing
- Reset values: state HDR_HI, rx_ready 1, cpu_hold 1, mem_we 0, mem_wdata 0, mem_addr 0, load_done 0, load_err 0, all counters 0.
- Write latency: 4th byte of a word accepted at cycle t → mem_we=1 with mem_wdata and mem_addr valid for exactly cycle t+1.
  - The next word's 1st byte can be accepted at t+1, so sustained throughput is 1 byte/cycle.
- Completion: final handshake at t → DONE at t+1 (final write lands here) → RUN at t+2.
  - At t+2: cpu_hold=0 and load_done=1 for that cycle only.
- N=0: HDR_LO accepted at t → DONE at t+1 → RUN at t+2. No writes occur.
- load_req outside RUN is ignored. In RUN, cpu_hold=1 and rx_ready=1 from the next cycle.
- load_err:
  - Set on the cycle of the error transition.
  - Cleared only by reset, or on the cycle a subsequent load reaches DONE.
- Async reset mid-load aborts immediately:
  - mem_we drops to 0 asynchronously and the partial word is discarded.
  - Words already written remain in memory.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - A 32-bit XOR of all N data words is accumulated.
  - CHK accepts 4 further bytes (MSB first).
  - Match → DONE.
  - Mismatch → load_err=1 and → HDR_HI; cpu_hold stays 1, and words already written are not rolled back.
  - For N=0 the header is followed by CHK, with expected value 0.
- Undefined: no CHK state and no accumulator. The stream ends after the last data byte.

## Structure
- Package imem_loader_pkg holds:
  - state encodings;
  - header length (2) and word byte count (4);
  - checksum width (32).
- Natural sub-module: imem_word_assembler. It is a 4-byte big-endian shift register with a byte counter and outputs word_valid and word. The FSM, mux and checksum stay in imem_loader.

## Test plan
- Reset, stream 00 02 | 24 08 00 05 | 00 00 00 08:
  - writes: mem[0]=0x24080005 and mem[1]=0x00000008, each one cycle after its 4th byte;
  - load_done pulses 2 cycles after the last byte, then cpu_hold=0;
  - in RUN, cpu_addr=0x4 → mem_addr=1.
- Header 00 81 with MEM_SIZE=128: load_err=1, no mem_we, back in HDR_HI, cpu_hold=1.
- Throttling: rx_valid toggled every other cycle during a 3-word load. Identical writes; no byte lost or duplicated.
- Reset asserted after byte 2 of word 1: outputs at reset values immediately. A fresh 1-word load then writes mem[0].
- With IMEM_LOADER_CHECKSUM_EN, words 0x11111111 and 0x22222222:
  - trailer 33 33 33 33 → load_done;
  - trailer 33 33 33 34 → load_err=1 and cpu_hold stays 1.
- In RUN, pulse load_req, then send header 00 00: cpu_hold high for exactly 3 cycles, no writes, load_done pulse.
